// File: rtl/frv_common_pkg.sv
// Shared FRV definitions: op-select width and bit positions, owner encoding,
// arbiter state encoding and a one-hot op helper.
package frv_common;

   // Width of the one-hot ALU operation-select vector.
   localparam int unsigned NOP = 33;

   // Bit positions inside the op-select vector (op_add .. op_sro order).
   localparam int unsigned OP_ADD    = 0;
   localparam int unsigned OP_SUB    = 1;
   localparam int unsigned OP_XOR    = 2;
   localparam int unsigned OP_OR     = 3;
   localparam int unsigned OP_AND    = 4;
   localparam int unsigned OP_SLT    = 5;
   localparam int unsigned OP_SLTU   = 6;
   localparam int unsigned OP_SLL    = 7;
   localparam int unsigned OP_SRL    = 8;
   localparam int unsigned OP_SRA    = 9;
   localparam int unsigned OP_ROL    = 10;
   localparam int unsigned OP_ROR    = 11;
   localparam int unsigned OP_ANDN   = 12;
   localparam int unsigned OP_ORN    = 13;
   localparam int unsigned OP_XNOR   = 14;
   localparam int unsigned OP_CLZ    = 15;
   localparam int unsigned OP_CTZ    = 16;
   localparam int unsigned OP_PCNT   = 17;
   localparam int unsigned OP_MIN    = 18;
   localparam int unsigned OP_MAX    = 19;
   localparam int unsigned OP_MINU   = 20;
   localparam int unsigned OP_MAXU   = 21;
   localparam int unsigned OP_SEXT_B = 22;
   localparam int unsigned OP_SEXT_H = 23;
   localparam int unsigned OP_ZEXT_H = 24;
   localparam int unsigned OP_REV8   = 25;
   localparam int unsigned OP_ORC_B  = 26;
   localparam int unsigned OP_BSET   = 27;
   localparam int unsigned OP_BCLR   = 28;
   localparam int unsigned OP_BINV   = 29;
   localparam int unsigned OP_BEXT   = 30;
   localparam int unsigned OP_SLO    = 31;
   localparam int unsigned OP_SRO    = 32;

   // Which requester owns the held result.
   typedef enum logic {
      OWN_P0 = 1'b0,
      OWN_P1 = 1'b1
   } owner_e;

   // Arbiter FSM: IDLE holds nothing, HOLD holds one result for the owner.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } arb_state_e;

   // One-hot op-select vector with bit idx set.
   function automatic logic [NOP-1:0] op_bit(input int unsigned idx);
      logic [NOP-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/frv_alu_arb_sel.sv
// 2:1 request mux toward the shared ALU, zero-gated when nothing is granted.
// Ports: sel0/sel1 grant strobes (at most one high); req0_*/req1_* request
// payloads; alu_* payload presented to the ALU (all-zero when idle).
module frv_alu_arb_sel #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NOP  = 33
) (
   input  logic            sel0,
   input  logic            sel1,
   input  logic [NOP-1:0]  req0_ops,
   input  logic [XLEN-1:0] req0_opr_a,
   input  logic [XLEN-1:0] req0_opr_b,
   input  logic [4:0]      req0_shamt,
   input  logic [NOP-1:0]  req1_ops,
   input  logic [XLEN-1:0] req1_opr_a,
   input  logic [XLEN-1:0] req1_opr_b,
   input  logic [4:0]      req1_shamt,
   output logic [NOP-1:0]  alu_ops,
   output logic [XLEN-1:0] alu_opr_a,
   output logic [XLEN-1:0] alu_opr_b,
   output logic [4:0]      alu_shamt
);

   // Zero by default so the ALU inputs do not toggle outside grant cycles.
   always_comb begin
      alu_ops   = '0;
      alu_opr_a = '0;
      alu_opr_b = '0;
      alu_shamt = '0;
      if (sel0) begin
         alu_ops   = req0_ops;
         alu_opr_a = req0_opr_a;
         alu_opr_b = req0_opr_b;
         alu_shamt = req0_shamt;
      end else if (sel1) begin
         alu_ops   = req1_ops;
         alu_opr_a = req1_opr_a;
         alu_opr_b = req1_opr_b;
         alu_shamt = req1_shamt;
      end
   end

endmodule

// File: rtl/frv_alu_arb.sv
// Two-requester arbiter in front of a shared ALU (pipeline = port 0,
// ISE/coprocessor = port 1). One outstanding transaction, latency 1,
// back-to-back grants when the owner consumes its result.
// Ports: g_clk/g_resetn clock and async active-low reset;
// req{0,1}_* request handshake + payload; rsp{0,1}_* result handshake;
// alu_* payload to the external ALU, alu_result returned from it.
module frv_alu_arb #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned NOP        = 33,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic            g_clk,
   input  logic            g_resetn,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [NOP-1:0]  req0_ops,
   input  logic [XLEN-1:0] req0_opr_a,
   input  logic [XLEN-1:0] req0_opr_b,
   input  logic [4:0]      req0_shamt,
   output logic            rsp0_valid,
   input  logic            rsp0_ready,
   output logic [XLEN-1:0] rsp0_result,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [NOP-1:0]  req1_ops,
   input  logic [XLEN-1:0] req1_opr_a,
   input  logic [XLEN-1:0] req1_opr_b,
   input  logic [4:0]      req1_shamt,
   output logic            rsp1_valid,
   input  logic            rsp1_ready,
   output logic [XLEN-1:0] rsp1_result,
   output logic [NOP-1:0]  alu_ops,
   output logic [XLEN-1:0] alu_opr_a,
   output logic [XLEN-1:0] alu_opr_b,
   output logic [4:0]      alu_shamt,
   input  logic [XLEN-1:0] alu_result
);

   import frv_common::*;

   localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   arb_state_e      state_q, state_d;
   owner_e          owner_q, owner_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [SW-1:0]   starve_q, starve_d;

   logic owner_rdy;
   logic can_grant;
   logic starve_hit;
   logic gnt0;
   logic gnt1;

   // State and datapath registers.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state_q  <= ST_IDLE;
         owner_q  <= OWN_P0;
         result_q <= '0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         result_q <= result_d;
         starve_q <= starve_d;
      end
   end

   // Grant decision, next state, result capture and starvation counter.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      result_d   = result_q;
      starve_d   = starve_q;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      owner_rdy  = (owner_q == OWN_P1) ? rsp1_ready : rsp0_ready;
      // A held result being consumed frees the slot in the same cycle.
      can_grant  = (state_q == ST_IDLE) || owner_rdy;
      starve_hit = req1_valid && (starve_q == STARVE_LIM);

      if (can_grant) begin
         if (req1_valid && (starve_hit || !req0_valid)) begin
            gnt1 = 1'b1;
         end else if (req0_valid) begin
            gnt0 = 1'b1;
         end
      end

      if (gnt0 || gnt1) begin
         state_d  = ST_HOLD;
         owner_d  = gnt1 ? OWN_P1 : OWN_P0;
         result_d = alu_result;
      end else if ((state_q == ST_HOLD) && owner_rdy) begin
         state_d = ST_IDLE;
      end

      // Counts every cycle requester 1 waits, granted slot or not.
      if (!req1_valid || gnt1) begin
         starve_d = '0;
      end else if (starve_q != STARVE_LIM) begin
         starve_d = starve_q + SW'(1);
      end
   end

   assign req0_ready  = gnt0;
   assign req1_ready  = gnt1;
   assign rsp0_valid  = (state_q == ST_HOLD) && (owner_q == OWN_P0);
   assign rsp1_valid  = (state_q == ST_HOLD) && (owner_q == OWN_P1);
   assign rsp0_result = rsp0_valid ? result_q : '0;
   assign rsp1_result = rsp1_valid ? result_q : '0;

   frv_alu_arb_sel #(
      .XLEN (XLEN),
      .NOP  (NOP)
   ) u_sel (
      .sel0       (gnt0),
      .sel1       (gnt1),
      .req0_ops   (req0_ops),
      .req0_opr_a (req0_opr_a),
      .req0_opr_b (req0_opr_b),
      .req0_shamt (req0_shamt),
      .req1_ops   (req1_ops),
      .req1_opr_a (req1_opr_a),
      .req1_opr_b (req1_opr_b),
      .req1_shamt (req1_shamt),
      .alu_ops    (alu_ops),
      .alu_opr_a  (alu_opr_a),
      .alu_opr_b  (alu_opr_b),
      .alu_shamt  (alu_shamt)
   );

endmodule

// File: tb/tb_frv_alu_arb.sv
// Directed bench for frv_alu_arb with a small behavioural ALU attached.
module tb_frv_alu_arb;

   import frv_common::*;

   localparam int unsigned XLEN = 32;

   logic            g_clk;
   logic            g_resetn;
   logic            req0_valid, req0_ready;
   logic [NOP-1:0]  req0_ops;
   logic [XLEN-1:0] req0_opr_a, req0_opr_b;
   logic [4:0]      req0_shamt;
   logic            rsp0_valid, rsp0_ready;
   logic [XLEN-1:0] rsp0_result;
   logic            req1_valid, req1_ready;
   logic [NOP-1:0]  req1_ops;
   logic [XLEN-1:0] req1_opr_a, req1_opr_b;
   logic [4:0]      req1_shamt;
   logic            rsp1_valid, rsp1_ready;
   logic [XLEN-1:0] rsp1_result;
   logic [NOP-1:0]  alu_ops;
   logic [XLEN-1:0] alu_opr_a, alu_opr_b;
   logic [4:0]      alu_shamt;
   logic [XLEN-1:0] alu_result;

   int n_cmp = 0;
   int n_err = 0;

   frv_alu_arb #(.XLEN(XLEN), .NOP(NOP), .STARVE_MAX(4)) dut (
      .g_clk       (g_clk),
      .g_resetn    (g_resetn),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_ops    (req0_ops),
      .req0_opr_a  (req0_opr_a),
      .req0_opr_b  (req0_opr_b),
      .req0_shamt  (req0_shamt),
      .rsp0_valid  (rsp0_valid),
      .rsp0_ready  (rsp0_ready),
      .rsp0_result (rsp0_result),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_ops    (req1_ops),
      .req1_opr_a  (req1_opr_a),
      .req1_opr_b  (req1_opr_b),
      .req1_shamt  (req1_shamt),
      .rsp1_valid  (rsp1_valid),
      .rsp1_ready  (rsp1_ready),
      .rsp1_result (rsp1_result),
      .alu_ops     (alu_ops),
      .alu_opr_a   (alu_opr_a),
      .alu_opr_b   (alu_opr_b),
      .alu_shamt   (alu_shamt),
      .alu_result  (alu_result)
   );

   // Stand-in for the external ALU: add/sub/xor only.
   always_comb begin
      alu_result = '0;
      if (alu_ops[OP_ADD])      alu_result = alu_opr_a + alu_opr_b;
      else if (alu_ops[OP_SUB]) alu_result = alu_opr_a - alu_opr_b;
      else if (alu_ops[OP_XOR]) alu_result = alu_opr_a ^ alu_opr_b;
   end

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sample point: 1 time unit after the rising edge.
   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask

   task automatic set_req0(input logic v, input int unsigned op,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [4:0] sh);
      req0_valid = v;
      req0_ops   = op_bit(op);
      req0_opr_a = a;
      req0_opr_b = b;
      req0_shamt = sh;
   endtask

   task automatic set_req1(input logic v, input int unsigned op,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [4:0] sh);
      req1_valid = v;
      req1_ops   = op_bit(op);
      req1_opr_a = a;
      req1_opr_b = b;
      req1_shamt = sh;
   endtask

   initial begin
      g_resetn   = 1'b0;
      req0_valid = 1'b0; req0_ops = '0; req0_opr_a = '0; req0_opr_b = '0; req0_shamt = '0;
      req1_valid = 1'b0; req1_ops = '0; req1_opr_a = '0; req1_opr_b = '0; req1_shamt = '0;
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;

      // Reset state
      #12;
      chk("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
      chk("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
      chk("rst_req0_ready", 64'(req0_ready), 64'd0);
      chk("rst_rsp0_result", 64'(rsp0_result), 64'd0);
      chk("rst_alu_ops", 64'(alu_ops), 64'd0);
      #8 g_resetn = 1'b1;
      tick();

      // Single add 5+7, held until consumed
      set_req0(1'b1, OP_ADD, 32'd5, 32'd7, 5'd3);
      #1;
      chk("add_req0_ready", 64'(req0_ready), 64'd1);
      chk("add_req1_ready", 64'(req1_ready), 64'd0);
      chk("add_alu_ops", 64'(alu_ops), 64'h1);
      chk("add_alu_a", 64'(alu_opr_a), 64'd5);
      chk("add_alu_shamt", 64'(alu_shamt), 64'd3);
      tick();
      set_req0(1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
      #1;
      chk("add_rsp0_valid", 64'(rsp0_valid), 64'd1);
      chk("add_rsp0_result", 64'(rsp0_result), 64'd12);
      chk("add_rsp1_valid", 64'(rsp1_valid), 64'd0);
      chk("add_rsp1_result", 64'(rsp1_result), 64'd0);
      chk("add_alu_gated", 64'(alu_ops), 64'd0);
      tick();
      chk("add_hold_valid", 64'(rsp0_valid), 64'd1);
      chk("add_hold_result", 64'(rsp0_result), 64'd12);
      rsp0_ready = 1'b1;
      tick();
      chk("add_drained", 64'(rsp0_valid), 64'd0);

      // Back-to-back sub then xor on port 0
      set_req0(1'b1, OP_SUB, 32'd10, 32'd3, 5'd0);
      #1;
      chk("b2b_sub_ready", 64'(req0_ready), 64'd1);
      tick();
      set_req0(1'b1, OP_XOR, 32'hF0, 32'hFF, 5'd0);
      #1;
      chk("b2b_sub_result", 64'(rsp0_result), 64'd7);
      chk("b2b_xor_ready", 64'(req0_ready), 64'd1);
      tick();
      set_req0(1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
      #1;
      chk("b2b_xor_valid", 64'(rsp0_valid), 64'd1);
      chk("b2b_xor_result", 64'(rsp0_result), 64'h0F);
      tick();
      chk("b2b_drained", 64'(rsp0_valid), 64'd0);
      rsp0_ready = 1'b0;

      // Port 1 holds with rsp1_ready low while req0 waits
      set_req1(1'b1, OP_ADD, 32'd1, 32'd2, 5'd0);
      #1;
      chk("hold_req1_ready", 64'(req1_ready), 64'd1);
      tick();
      set_req1(1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
      set_req0(1'b1, OP_ADD, 32'd3, 32'd4, 5'd0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("hold_no_grant", 64'(req0_ready), 64'd0);
         chk("hold_rsp1_valid", 64'(rsp1_valid), 64'd1);
         chk("hold_rsp1_result", 64'(rsp1_result), 64'd3);
         chk("hold_rsp0_result", 64'(rsp0_result), 64'd0);
         chk("hold_alu_gated", 64'(alu_opr_a), 64'd0);
         tick();
      end
      rsp1_ready = 1'b1;
      #1;
      chk("hold_release_grant", 64'(req0_ready), 64'd1);
      tick();
      set_req0(1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
      rsp1_ready = 1'b0;
      #1;
      chk("hold_rsp1_gone", 64'(rsp1_valid), 64'd0);
      chk("hold_rsp0_valid", 64'(rsp0_valid), 64'd1);
      chk("hold_rsp0_value", 64'(rsp0_result), 64'd7);
      rsp0_ready = 1'b1;
      tick();
      chk("hold_drained", 64'(rsp0_valid), 64'd0);

      // Starvation: both valid every cycle -> 4x req0 then 1x req1
      rsp1_ready = 1'b1;
      set_req0(1'b1, OP_ADD, 32'd1, 32'd1, 5'd0);
      set_req1(1'b1, OP_ADD, 32'd2, 32'd2, 5'd0);
      for (int k = 0; k < 10; k++) begin
         #1;
         chk("starve_req0_ready", 64'(req0_ready), (k % 5 != 4) ? 64'd1 : 64'd0);
         chk("starve_req1_ready", 64'(req1_ready), (k % 5 == 4) ? 64'd1 : 64'd0);
         tick();
         if (k == 4) begin
            chk("starve_rsp1_result", 64'(rsp1_result), 64'd4);
            chk("starve_rsp0_valid", 64'(rsp0_valid), 64'd0);
         end
      end
      set_req0(1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
      set_req1(1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
      tick();
      chk("starve_drained", 64'(rsp0_valid | rsp1_valid), 64'd0);
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;

      // No valid request: ALU inputs stay zero even with payload present
      set_req0(1'b0, OP_SUB, 32'd55, 32'd66, 5'd9);
      set_req1(1'b0, OP_XOR, 32'd77, 32'd88, 5'd4);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("idle_alu_ops", 64'(alu_ops), 64'd0);
         chk("idle_alu_a", 64'(alu_opr_a), 64'd0);
         chk("idle_alu_b", 64'(alu_opr_b), 64'd0);
         chk("idle_alu_shamt", 64'(alu_shamt), 64'd0);
         chk("idle_ready", 64'(req0_ready | req1_ready), 64'd0);
         tick();
      end

      // Reset during HOLD discards the result
      set_req0(1'b1, OP_ADD, 32'd5, 32'd7, 5'd0);
      tick();
      set_req0(1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
      #1;
      chk("rh_valid_before", 64'(rsp0_valid), 64'd1);
      g_resetn = 1'b0;
      #1;
      chk("rh_valid_reset", 64'(rsp0_valid), 64'd0);
      chk("rh_result_reset", 64'(rsp0_result), 64'd0);
      tick();
      g_resetn = 1'b1;
      tick();
      chk("rh_after_release", 64'(rsp0_valid), 64'd0);
      set_req0(1'b1, OP_ADD, 32'd2, 32'd2, 5'd0);
      #1;
      chk("rh_req0_ready", 64'(req0_ready), 64'd1);
      tick();
      set_req0(1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
      #1;
      chk("rh_rsp0_valid", 64'(rsp0_valid), 64'd1);
      chk("rh_rsp0_result", 64'(rsp0_result), 64'd4);
      rsp0_ready = 1'b1;
      tick();
      chk("rh_drained", 64'(rsp0_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/frv_alu_arb.md
FRV_ALU_ARB -- requirements
Module: frv_alu_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NOP, default 33, width of the one-hot ALU operation-select vector (op_add..op_sro order).
REQ-003 SHALL have parameter STARVE_MAX, default 4, consecutive lost-arbitration cycles after which requester 1 is forced a grant.
REQ-004 Ports (name direction width meaning):
- g_clk  in  1  clock
- g_resetn  in  1  asynchronous active-low reset
- req0_valid  in  1  pipeline request valid
- req0_ready  out  1  pipeline request accepted
- req0_ops  in  NOP  one-hot op select
- req0_opr_a, req0_opr_b  in  XLEN  operands
- req0_shamt  in  5  shift amount
- rsp0_valid  out  1  pipeline result valid
- rsp0_ready  in  1  pipeline result consumed
- rsp0_result  out  XLEN  result
- req1_*, rsp1_*  same set for requester 1 (ISE / coprocessor)
- alu_ops  out  NOP  to ALU op inputs
- alu_opr_a, alu_opr_b  out  XLEN  to ALU operands
- alu_shamt  out  5  to ALU shamt
- alu_result  in  XLEN  from ALU result
REQ-005 One clock g_clk; reset g_resetn is asynchronous and active-low.

Function
REQ-006 SHALL implement FSM states IDLE (no result held) and HOLD (one result held for owner port); at most one outstanding transaction.
REQ-007 SHALL grant when state is IDLE, or HOLD with the owning rsp*_ready=1 in the same cycle (back-to-back, no bubble).
REQ-008 Grant rule: req0 wins over req1, except when starve_cnt==STARVE_MAX and req1_valid=1, then req1 wins.
REQ-009 starve_cnt SHALL increment (saturating at STARVE_MAX) each cycle req1_valid=1 and req1 is not granted; SHALL clear on req1 grant or req1_valid=0.
REQ-010 req*_ready SHALL be 1 only for the granted port in a grant cycle; handshake completes on valid&&ready.
REQ-011 In the grant cycle alu_* SHALL be driven combinationally from the granted port's request; otherwise alu_ops, alu_opr_a, alu_opr_b, alu_shamt SHALL be all-zero (toggle gating).
REQ-012 alu_result SHALL be registered at the end of the grant cycle; rsp*_valid for the owner SHALL rise the next cycle (latency 1).
REQ-013 rsp*_valid and rsp*_result SHALL remain stable until rsp*_ready=1; rsp*_ready while rsp*_valid=0 SHALL be ignored.
REQ-014 Only the owner port's rsp_valid SHALL ever be 1; the other port's rsp_result SHALL read zero.
REQ-015 HOLD -> IDLE when owner rsp_ready=1 and no grant that cycle; HOLD -> HOLD with new owner on a back-to-back grant.
REQ-016 A request withdrawn before ready SHALL have no effect; request content is not required to be stable before grant.

Reset
REQ-017 On g_resetn=0: state IDLE, starve_cnt 0, result register 0, all rsp*_valid 0, all req*_ready 0, alu_* 0.
REQ-018 Reset mid-HOLD SHALL discard the held result with no response emitted.
REQ-019 Outputs SHALL depend only on state and current inputs; no registered output change on the reset-release edge.

Structure
REQ-020 NOP, the op-select bit index localparams and the owner encoding (OWN_P0, OWN_P1) SHALL live in the shared package frv_common.
REQ-021 The ALU SHALL NOT be instantiated inside this block; it is instantiated alongside it, with alu_* ports connected 1:1.
REQ-022 A single sub-module frv_alu_arb_sel (2:1 request mux with zero gating) is permitted; everything else is flat.

Verification
REQ-023 IDLE, req0 add 5+7 -> req0_ready=1 same cycle; rsp0_valid=1 next cycle with 12; held until rsp0_ready.
REQ-024 req0 and req1 both valid every cycle, rsp*_ready=1 -> req0 granted 4 times, req1 granted on the 5th; repeating pattern.
REQ-025 HOLD for port 1 with rsp1_ready=0 for 3 cycles, req0 pending -> no grant and rsp1_result stable; grant to req0 in the cycle rsp1_ready=1.
REQ-026 Back-to-back req0 sub 10-3 then xor 0xF0^0xFF, rsp0_ready=1 -> results 7 and 0x0F on consecutive cycles with no bubble.
REQ-027 Assert g_resetn=0 during HOLD -> rsp0_valid=0 immediately; after release the first request completes normally.
REQ-028 No valid requests -> alu_ops, alu_opr_a, alu_opr_b, alu_shamt all zero every cycle.
